// File: rtl/wb_mem_responder.sv
// Memory-side responder for the ao486 memory bus.
// Services Wishbone classic and incremental-burst writes, plus
// readdatavalid-style read bursts, from an internal word-wide RAM
// with per-byte write enables.
module wb_mem_responder #(
  parameter int ADDR_W       = 10,
  parameter int WAIT_STATES  = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  input  logic        wb_read_i,
  input  logic [2:0]  wb_burstcount_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_readdatavalid_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int         HI_W     = 30 - ADDR_W;
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [2:0] WS_LOAD  = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [2:0] RL_LOAD  = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_WAIT = 3'd1,
    W_ACK  = 3'd2,
    W_GAP  = 3'd3,
    R_LAT  = 3'd4,
    R_DATA = 3'd5
  } state_t;

  // Burst length 1..4 is honoured; anything else means a full 4-beat burst.
  function automatic logic [2:0] decode_beats(input logic [2:0] bc);
    case (bc)
      3'd1, 3'd2, 3'd3, 3'd4: decode_beats = bc;
      default:                decode_beats = 3'd4;
    endcase
  endfunction

  logic [31:0]       mem_r [2**ADDR_W];

  state_t            state_r;
  logic [ADDR_W-1:0] base_idx_r;
  logic [ADDR_W-1:0] offset_r;
  logic              in_range_r;
  logic [2:0]        cnt_r;
  logic [2:0]        beats_r;
  logic [2:0]        last_cti_r;
  logic [31:0]       dat_r;
  logic              ack_r;
  logic              rdv_r;
  logic              err_r;

  logic [ADDR_W-1:0] word_idx_s;
  logic              req_in_range_s;
  logic              last_beat_s;
  logic              burst_more_s;
  logic              mem_we_s;
  logic              unused_s;

  // Address arithmetic and transfer-continuation decisions.
  always_comb begin
    word_idx_s     = base_idx_r + offset_r;
    req_in_range_s = (wb_adr_i[31:ADDR_W+2] == {HI_W{1'b0}});
    last_beat_s    = (offset_r == ADDR_W'(beats_r - 3'd1));
    // The cti of the beat just acked decides whether another one follows:
    // classic (000) and end-of-burst (111) both close the cycle.
    burst_more_s   = wb_cyc_i && wb_stb_i &&
                     (last_cti_r != 3'b111) && (last_cti_r != 3'b000);
    // The write lands on the edge that closes the ack cycle, so a reset
    // arriving earlier leaves the RAM untouched.
    mem_we_s       = (state_r == W_ACK) && in_range_r;
    unused_s       = ^{wb_bte_i, wb_adr_i[1:0]};
  end

  // Byte-enabled RAM write using bus values sampled at the end of the ack cycle.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (wb_sel_i[k]) begin
          mem_r[word_idx_s][8*k +: 8] <= wb_dat_i[8*k +: 8];
        end
      end
    end
  end

  // Transfer sequencing with all bus outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      base_idx_r <= '0;
      offset_r   <= '0;
      in_range_r <= 1'b0;
      cnt_r      <= 3'd0;
      beats_r    <= 3'd0;
      last_cti_r <= 3'd0;
      dat_r      <= 32'd0;
      ack_r      <= 1'b0;
      rdv_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      rdv_r <= 1'b0;
      err_r <= 1'b0;
      dat_r <= 32'd0;
      case (state_r)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i && wb_we_i) begin
            base_idx_r <= wb_adr_i[ADDR_W+1:2];
            in_range_r <= req_in_range_s;
            offset_r   <= '0;
            if (HAS_WAIT) begin
              cnt_r   <= WS_LOAD;
              state_r <= W_WAIT;
            end else begin
              ack_r   <= req_in_range_s;
              err_r   <= !req_in_range_s;
              state_r <= W_ACK;
            end
          end else if (wb_read_i) begin
            base_idx_r <= wb_adr_i[ADDR_W+1:2];
            in_range_r <= req_in_range_s;
            offset_r   <= '0;
            beats_r    <= decode_beats(wb_burstcount_i);
            cnt_r      <= RL_LOAD;
            ack_r      <= 1'b1;
            state_r    <= R_LAT;
          end else begin
            state_r <= IDLE;
          end
        end
        W_WAIT: begin
          if (!wb_cyc_i) begin
            offset_r <= '0;
            state_r  <= IDLE;
          end else if (cnt_r == 3'd0) begin
            ack_r   <= in_range_r;
            err_r   <= !in_range_r;
            state_r <= W_ACK;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        W_ACK: begin
          offset_r   <= offset_r + ADDR_W'(1);
          last_cti_r <= wb_cti_i;
          state_r    <= W_GAP;
        end
        W_GAP: begin
          if (burst_more_s) begin
            if (HAS_WAIT) begin
              cnt_r   <= WS_LOAD;
              state_r <= W_WAIT;
            end else begin
              ack_r   <= in_range_r;
              err_r   <= !in_range_r;
              state_r <= W_ACK;
            end
          end else begin
            offset_r <= '0;
            state_r  <= IDLE;
          end
        end
        R_LAT, R_DATA: begin
          // Each emitting edge loads one beat into the output registers.
          if ((state_r == R_DATA) || (cnt_r == 3'd0)) begin
            rdv_r <= 1'b1;
            err_r <= !in_range_r;
            dat_r <= in_range_r ? mem_r[word_idx_s] : 32'd0;
            if (last_beat_s) begin
              offset_r <= '0;
              state_r  <= IDLE;
            end else begin
              offset_r <= offset_r + ADDR_W'(1);
              state_r  <= R_DATA;
            end
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        default: begin
          offset_r <= '0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign wb_dat_o           = dat_r;
  assign wb_ack_o           = ack_r;
  assign wb_readdatavalid_o = rdv_r;
  assign wb_err_o           = err_r;
  assign wb_rty_o           = 1'b0;

endmodule
